// File: rtl/pagerank_pkg.sv
// pagerank_pkg: shared state encoding and fixed-point helpers for the PageRank engine
package pagerank_pkg;
  typedef enum logic [2:0] {IDLE, INIT, ACCUM, WRITE, CHECK, DONE} state_t;
  function automatic logic [63:0] base(input int unsigned w);
    return 64'd1 << w;
  endfunction
  function automatic logic [63:0] init_val(input int unsigned w, input int unsigned n);
    return base(w) / 64'(n);
  endfunction
  function automatic logic [63:0] teleport(input logic [63:0] d, input int unsigned n);
    return d / 64'(n);
  endfunction
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
    return (a + b >= base(w)) ? base(w) - 64'd1 : a + b;
  endfunction
endpackage

// File: rtl/pagerank_mac.sv
// pagerank_mac: damped weighted MAC with top-WIDTH truncation and saturating accumulate
module pagerank_mac
  import pagerank_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] DB     = '0,
  parameter logic [WIDTH-1:0] LOAD_V = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] acc
);
  localparam int PW = 3 * WIDTH;
  logic [PW-1:0] prod;
  logic [WIDTH-1:0] acc_d, acc_q;
  always_comb begin
    prod  = PW'(DB) * PW'(w) * PW'(val);
    acc_d = load ? LOAD_V : en ? WIDTH'(sat_add(64'(acc_q), 64'(prod >> (2 * WIDTH)), WIDTH)) : acc_q;
  end
  always_ff @(posedge clk) acc_q <= reset ? '0 : acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/pagerank_iter_engine.sv
// pagerank_iter_engine: sequential Jacobi PageRank solver, one MAC per clock
module pagerank_iter_engine
  import pagerank_pkg::*;
#(
  parameter int               N        = 4,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] D        = 16'h2666,
  parameter int               MAX_ITER = 32,
  parameter logic [WIDTH-1:0] EPS      = 16'h0010
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N*N-1:0]                adjacency,
  input  logic [N*WIDTH-1:0]            weights,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
  input  logic [$clog2(N)-1:0]          rd_addr,
  output logic [WIDTH-1:0]              rd_data
);
  localparam int AW = $clog2(N);
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(init_val(WIDTH, N));
  localparam logic [WIDTH-1:0] TELE   = WIDTH'(teleport(64'(D), N));
  localparam logic [WIDTH-1:0] DB     = WIDTH'(base(WIDTH) - 64'(D));
  localparam logic [AW-1:0]    LAST   = AW'(N - 1);
  state_t state_d, state_q;
  logic [AW-1:0] p_d, p_q, k_d, k_q;
  logic [IW-1:0] iter_d, iter_q;
  logic sel_d, sel_q, conv_d, conv_q, mac_load, mac_en;
  logic [WIDTH-1:0] maxd_d, maxd_q, acc, old, diff;
  logic [N-1:0] adj_d [N], adj_q [N];
  logic [WIDTH-1:0] w_d [N], w_q [N];
  logic [WIDTH-1:0] bank_d [2][N], bank_q [2][N];
  // sel_q names the committed bank; the other one collects the iteration in flight
  assign old  = bank_q[sel_q][p_q];
  assign diff = acc > old ? acc - old : old - acc;
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    k_d      = k_q;
    iter_d   = iter_q;
    sel_d    = sel_q;
    conv_d   = conv_q;
    maxd_d   = maxd_q;
    adj_d    = adj_q;
    w_d      = w_q;
    bank_d   = bank_q;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = INIT;
        conv_d  = 1'b0;
        for (int i = 0; i < N; i++) begin
          adj_d[i] = adjacency[i*N +: N];
          w_d[i]   = weights[i*WIDTH +: WIDTH];
        end
      end
      INIT: begin
        state_d  = ACCUM;
        iter_d   = '0;
        p_d      = '0;
        k_d      = '0;
        maxd_d   = '0;
        mac_load = 1'b1;
        for (int i = 0; i < N; i++) bank_d[sel_q][i] = INIT_V;
      end
      ACCUM: begin
        mac_en  = adj_q[p_q][k_q];
        k_d     = (k_q == LAST) ? '0 : k_q + 1'b1;
        state_d = (k_q == LAST) ? WRITE : ACCUM;
      end
      WRITE: begin
        bank_d[~sel_q][p_q] = acc;
        maxd_d   = diff > maxd_q ? diff : maxd_q;
        mac_load = 1'b1;
        p_d      = (p_q == LAST) ? '0 : p_q + 1'b1;
        state_d  = (p_q == LAST) ? CHECK : ACCUM;
      end
      CHECK: begin
        sel_d   = ~sel_q;
        iter_d  = iter_q + 1'b1;
        maxd_d  = '0;
        conv_d  = maxd_q <= EPS;
        state_d = (maxd_q <= EPS || iter_d == IW'(MAX_ITER)) ? DONE : ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      k_q     <= '0;
      iter_q  <= '0;
      sel_q   <= 1'b0;
      conv_q  <= 1'b0;
      maxd_q  <= '0;
      for (int i = 0; i < N; i++) begin
        adj_q[i]     <= '0;
        w_q[i]       <= '0;
        bank_q[0][i] <= INIT_V;
        bank_q[1][i] <= INIT_V;
      end
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      k_q     <= k_d;
      iter_q  <= iter_d;
      sel_q   <= sel_d;
      conv_q  <= conv_d;
      maxd_q  <= maxd_d;
      adj_q   <= adj_d;
      w_q     <= w_d;
      bank_q  <= bank_d;
    end
  end
  pagerank_mac #(.WIDTH(WIDTH), .DB(DB), .LOAD_V(TELE)) u_mac (
    .clk  (clk),
    .reset(reset),
    .load (mac_load),
    .en   (mac_en),
    .w    (w_q[k_q]),
    .val  (bank_q[sel_q][k_q]),
    .acc  (acc)
  );
  assign busy       = state_q inside {INIT, ACCUM, WRITE, CHECK};
  assign done       = state_q == DONE;
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign rd_data    = (32'(rd_addr) < N) ? bank_q[sel_q][rd_addr] : '0;
endmodule
